quadrilatero_pe_pipe: RTL and testbench

Next-generation systolic-array processing element. Integer multiply-accumulate with a parametrised MAC pipeline depth and a parametrised word count. Has an elastic valid/ready handshake, a result-completion pulse and a completed-MAC counter, so the array controller sees exactly when each pump finishes, including multi-cycle and stalled MACs. Sits in the array grid: operands enter from the left and top, data is forwarded right, and the accumulator result goes down.

---
 rtl/quadrilatero_pe_pipe.sv | 167 ++++++++++++++++
 tb/tb_quadrilatero_pe_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/quadrilatero_pe_pipe.sv
// Systolic-array PE: elastic multi-stage integer MAC with completion pulse and counter.
// Define QUADRILATERO_PE_SAT_EN to saturate SIZE_16/SIZE_8 accumulation per 32-bit word.
module quadrilatero_pe_pipe #(
   parameter int DATA_WIDTH  = 32,
   parameter int MAC_LATENCY = 2,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [1:0]            datatype_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [DATA_WIDTH-1:0] weight_i,
   input  logic [DATA_WIDTH-1:0] acc_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [1:0]            datatype_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DATA_WIDTH-1:0] acc_o,
   output logic                  pump_done_o,
   output logic                  busy_o,
   output logic [CNT_WIDTH-1:0]  mac_count_o
);

   localparam int NW = DATA_WIDTH / 32;

   localparam logic [1:0] SIZE_16 = 2'b01;
   localparam logic [1:0] SIZE_8  = 2'b10;

`ifdef QUADRILATERO_PE_SAT_EN
   localparam int ACC_W = 34;
`else
   localparam int ACC_W = 32;
`endif

   // One 32-bit word of the MAC; reserved datatype falls through to the SIZE_32 path.
   function automatic logic [31:0] mac_word(input logic [31:0] d, input logic [31:0] w,
                                            input logic [31:0] a, input logic [1:0] dt);
      logic signed [ACC_W-1:0] sum;
      logic signed [31:0]      prod;
      logic [31:0]             res;
      sum  = ACC_W'($signed(a));
      prod = '0;
      res  = a + d * w;
      case (dt)
         SIZE_16: begin
            for (int k = 0; k < 2; k++) begin
               prod = $signed({{16{d[16*k+15]}}, d[16*k +: 16]})
                    * $signed({{16{w[16*k+15]}}, w[16*k +: 16]});
               sum  = sum + ACC_W'(prod);
            end
         end
         SIZE_8: begin
            for (int k = 0; k < 4; k++) begin
               prod = $signed({{24{d[8*k+7]}}, d[8*k +: 8]})
                    * $signed({{24{w[8*k+7]}}, w[8*k +: 8]});
               sum  = sum + ACC_W'(prod);
            end
         end
         default: ;
      endcase
      if (dt == SIZE_16 || dt == SIZE_8) begin
`ifdef QUADRILATERO_PE_SAT_EN
         if (sum[33:31] == 3'b000 || sum[33:31] == 3'b111) res = sum[31:0];
         else if (sum[33])                                 res = 32'h8000_0000;
         else                                              res = 32'h7FFF_FFFF;
`else
         res = sum[31:0];
`endif
      end
      return res;
   endfunction

   logic [MAC_LATENCY:1]  v_q;
   logic [MAC_LATENCY:1]  adv;
   logic                  accept;
   logic [DATA_WIDTH-1:0] op_d_q, op_w_q, op_a_q;
   logic [1:0]            op_dt_q;
   logic [DATA_WIDTH-1:0] res_comb;
   logic [CNT_WIDTH-1:0]  cnt_q;

   // Elastic advance: a stage moves on when its successor is empty or itself moving.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      adv              = '0;
      adv[MAC_LATENCY] = v_q[MAC_LATENCY] && ready_i;
      for (int i = MAC_LATENCY - 1; i >= 1; i--) begin
         adv[i] = v_q[i] && (!v_q[i+1] || adv[i+1]);
      end
   end

   assign ready_o     = !v_q[1] || adv[1];
   assign accept      = valid_i && ready_o && !flush_i;
   assign valid_o     = v_q[MAC_LATENCY];
   assign pump_done_o = v_q[MAC_LATENCY] && ready_i && !flush_i;
   assign busy_o      = |v_q;
   assign mac_count_o = cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so all stages update together.
      if (!rst_ni) begin
         v_q <= '0;
      end else if (flush_i) begin
         v_q <= '0;
      end else begin
         v_q[1] <= accept || (v_q[1] && !adv[1]);
         for (int i = 2; i <= MAC_LATENCY; i++) begin
            v_q[i] <= adv[i-1] || (v_q[i] && !adv[i]);
         end
      end
   end

   // NOTE: datapath registers are reset too, so every output reads zero out of reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_d_q     <= '0;
         op_w_q     <= '0;
         op_a_q     <= '0;
         op_dt_q    <= '0;
         data_o     <= '0;
         datatype_o <= '0;
      end else if (accept) begin
         op_d_q     <= data_i;
         op_w_q     <= weight_i;
         op_a_q     <= acc_i;
         op_dt_q    <= datatype_i;
         data_o     <= data_i;
         datatype_o <= datatype_i;
      end
   end

   always_comb begin
      res_comb = '0;
      for (int w = 0; w < NW; w++) begin
         res_comb[32*w +: 32] = mac_word(op_d_q[32*w +: 32], op_w_q[32*w +: 32],
                                         op_a_q[32*w +: 32], op_dt_q);
      end
   end

   // Result stages only load on a real advance, so acc_o holds through stalls and flushes.
   if (MAC_LATENCY == 1) begin : g_lat1
      assign acc_o = res_comb;
   end else begin : g_latn
      logic [DATA_WIDTH-1:0] res_q [2:MAC_LATENCY];

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int i = 2; i <= MAC_LATENCY; i++) res_q[i] <= '0;
         end else if (!flush_i) begin
            if (adv[1]) res_q[2] <= res_comb;
            for (int i = 3; i <= MAC_LATENCY; i++) begin
               if (adv[i-1]) res_q[i] <= res_q[i-1];
            end
         end
      end

      assign acc_o = res_q[MAC_LATENCY];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)          cnt_q <= '0;
      else if (pump_done_o) cnt_q <= cnt_q + CNT_WIDTH'(1);
   end

endmodule

// File: tb/tb_quadrilatero_pe_pipe.sv
// Self-checking bench for quadrilatero_pe_pipe: vector table, scoreboard queue, stall/flush/reset/wrap sequences.
module tb_quadrilatero_pe_pipe;

   localparam int DW  = 32;
   localparam int LAT = 2;
   localparam int CW  = 4;

   logic          clk_i, rst_ni, flush_i, valid_i, ready_o, ready_i;
   logic [1:0]    datatype_i, datatype_o;
   logic [DW-1:0] data_i, weight_i, acc_i, data_o, acc_o;
   logic          valid_o, pump_done_o, busy_o;
   logic [CW-1:0] mac_count_o;

   quadrilatero_pe_pipe #(.DATA_WIDTH(DW), .MAC_LATENCY(LAT), .CNT_WIDTH(CW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
      .datatype_i(datatype_i), .data_i(data_i), .weight_i(weight_i), .acc_i(acc_i),
      .data_o(data_o), .datatype_o(datatype_o), .valid_o(valid_o), .ready_i(ready_i),
      .acc_o(acc_o), .pump_done_o(pump_done_o), .busy_o(busy_o), .mac_count_o(mac_count_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      string       name;
      logic [1:0]  dt;
      logic [31:0] d, w, a, e;
   } vec_t;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];
   bit          saw_not_ready;
   logic        mon_pd;
   logic [31:0] mon_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Independent reference: generic lane loop over sign-extended 64-bit integers.
   function automatic logic [31:0] ref_mac(input logic [31:0] d, input logic [31:0] w,
                                           input logic [31:0] a, input logic [1:0] dt);
      int          lanes = (dt == 2'b01) ? 2 : (dt == 2'b10) ? 4 : 1;
      int          lw    = 32 / lanes;
      longint      sum   = longint'($signed(a));
      logic [63:0] r;
      for (int k = 0; k < lanes; k++) begin
         longint x = (longint'(d) >> (k * lw)) & ((longint'(1) << lw) - 1);
         longint y = (longint'(w) >> (k * lw)) & ((longint'(1) << lw) - 1);
         if (x >= (longint'(1) << (lw - 1))) x -= (longint'(1) << lw);
         if (y >= (longint'(1) << (lw - 1))) y -= (longint'(1) << lw);
         sum += x * y;
      end
`ifdef QUADRILATERO_PE_SAT_EN
      if (lanes > 1) begin
         if (sum > 64'sd2147483647)       sum = 64'sd2147483647;
         else if (sum < -64'sd2147483648) sum = -64'sd2147483648;
      end
`endif
      r = sum;
      return r[31:0];
   endfunction

   // Scoreboard: every predicted result handshake pops one expectation.
   always begin
      @(negedge clk_i);
      #2;
      if (rst_ni) begin
         mon_pd = valid_o && ready_i && !flush_i;
         check("pump_done_o", 32'(pump_done_o), 32'(mon_pd));
         if (mon_pd) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL acc_o: got %h expected no result (t=%0t)", acc_o, $time);
            end else begin
               mon_exp = exp_q.pop_front();
               check("acc_o", acc_o, mon_exp);
            end
         end
      end
   end

   task automatic send(input logic [1:0] dt, input logic [31:0] d, input logic [31:0] w,
                       input logic [31:0] a, input logic [31:0] e);
      int n = 0;
      @(negedge clk_i);
      valid_i = 1'b1; datatype_i = dt; data_i = d; weight_i = w; acc_i = a;
      #1;
      while (!ready_o && n < 100) begin
         saw_not_ready = 1'b1;
         n++;
         @(negedge clk_i);
         #1;
      end
      if (!ready_o) begin
         n_checks++;
         n_errors++;
         $display("FAIL accept_timeout: got ready_o=0 expected 1 within 100 cycles");
      end else begin
         exp_q.push_back(e);
      end
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      @(negedge clk_i);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        tbl[8];
      logic [CW-1:0] cnt0;
      logic [31:0] hold_data, hold_acc;
      logic [CW-1:0] hold_cnt;

      tbl[0] = '{"s32_basic",  2'b00, 32'h0000_0003, 32'hFFFF_FFFC, 32'd10,        32'hFFFF_FFFE};
      tbl[1] = '{"s8_basic",   2'b10, 32'h0102_0304, 32'h0101_0101, 32'd0,         32'd10};
      tbl[2] = '{"s16_basic",  2'b01, 32'h0002_FFFF, 32'h0003_0002, 32'd1,         32'd5};
`ifdef QUADRILATERO_PE_SAT_EN
      tbl[3] = '{"s8_pos_ovf", 2'b10, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 32'h7FFF_FFF0, 32'h7FFF_FFFF};
      tbl[4] = '{"s16_neg_ovf",2'b01, 32'h8000_8000, 32'h7FFF_7FFF, 32'h8000_0000, 32'h8000_0000};
`else
      tbl[3] = '{"s8_pos_ovf", 2'b10, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 32'h7FFF_FFF0, 32'h8000_FBF4};
      tbl[4] = '{"s16_neg_ovf",2'b01, 32'h8000_8000, 32'h7FFF_7FFF, 32'h8000_0000, 32'h0001_0000};
`endif
      tbl[5] = '{"reserved",   2'b11, 32'h0000_0003, 32'hFFFF_FFFC, 32'd10,        32'hFFFF_FFFE};
      tbl[6] = '{"s32_wrap",   2'b00, 32'h0001_0000, 32'h0001_0000, 32'd5,         32'd5};
      tbl[7] = '{"s8_signed",  2'b10, 32'hFF80_FF01, 32'h02FF_0203, 32'd0,         32'h0000_007F};

      rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
      datatype_i = '0; data_i = '0; weight_i = '0; acc_i = '0;
      saw_not_ready = 1'b0;
      #1;
      check("rst_ready_o", 32'(ready_o), 32'd1);
      check("rst_valid_o", 32'(valid_o), 32'd0);
      check("rst_busy_o",  32'(busy_o),  32'd0);
      check("rst_count",   32'(mac_count_o), 32'd0);
      check("rst_acc_o",   acc_o,  32'd0);
      check("rst_data_o",  data_o, 32'd0);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;

      // First transaction: latency, forwarding, pulse and count.
      send(2'b00, 32'd3, 32'hFFFF_FFFC, 32'd10, 32'hFFFF_FFFE);
      check("t1_data_o",     data_o, 32'd3);
      check("t1_datatype_o", 32'(datatype_o), 32'd0);
      check("t1_valid_early",32'(valid_o), 32'd0);
      check("t1_busy",       32'(busy_o), 32'd1);
      @(posedge clk_i); #1;
      check("t1_valid_o",    32'(valid_o), 32'd1);
      check("t1_acc_o",      acc_o, 32'hFFFF_FFFE);
      check("t1_pump_done",  32'(pump_done_o), 32'd1);
      @(posedge clk_i); #1;
      check("t1_count",      32'(mac_count_o), 32'd1);
      check("t1_idle",       32'(busy_o), 32'd0);

      // Vector table, streamed back to back.
      for (int i = 0; i < 8; i++) send(tbl[i].dt, tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].e);
      drain();
      check("table_count", 32'(mac_count_o), 32'd9);

      // Back-to-back stream with a downstream stall in cycles 3..6.
      saw_not_ready = 1'b0;
      cnt0 = mac_count_o;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               logic [31:0] d, w, a;
               logic [1:0]  dt;
               d = $urandom; w = $urandom; a = $urandom; dt = 2'($urandom_range(0, 3));
               send(dt, d, w, a, ref_mac(d, w, a, dt));
            end
         end
         begin
            for (int c = 0; c < 14; c++) begin
               @(negedge clk_i);
               ready_i = !(c >= 3 && c <= 6);
            end
         end
      join
      ready_i = 1'b1;
      drain();
      check("stall_ready_dropped", 32'(saw_not_ready), 32'd1);
      check("stream_count", 32'(mac_count_o), 32'(CW'(cnt0 + CW'(8))));

      // Flush with two results in flight and a new operand offered.
      ready_i = 1'b0;
      send(2'b00, 32'h0000_0011, 32'd2, 32'd1, 32'd35);
      send(2'b00, 32'h0000_0022, 32'd2, 32'd1, 32'd69);
      @(negedge clk_i);
      valid_i = 1'b1; flush_i = 1'b1; data_i = 32'hDEAD_BEEF; datatype_i = 2'b10;
      #1;
      hold_data = data_o; hold_acc = acc_o; hold_cnt = mac_count_o;
      check("pre_flush_acc", hold_acc, 32'd35);
      @(negedge clk_i);
      valid_i = 1'b0; flush_i = 1'b0;
      #1;
      check("flush_busy",   32'(busy_o), 32'd0);
      check("flush_valid",  32'(valid_o), 32'd0);
      check("flush_pulse",  32'(pump_done_o), 32'd0);
      check("flush_data_o", data_o, 32'h0000_0022);
      check("flush_dt_o",   32'(datatype_o), 32'd0);
      check("flush_acc_o",  acc_o, hold_acc);
      check("flush_count",  32'(mac_count_o), 32'(hold_cnt));
      exp_q.delete();
      ready_i = 1'b1;

      // Asynchronous reset in the middle of a held stream.
      ready_i = 1'b0;
      send(2'b01, 32'h1234_5678, 32'h0101_0101, 32'd7, 32'd0);
      send(2'b10, 32'h5555_AAAA, 32'h0303_0303, 32'd9, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      exp_q.delete();
      check("mid_rst_data_o",  data_o, 32'd0);
      check("mid_rst_dt_o",    32'(datatype_o), 32'd0);
      check("mid_rst_acc_o",   acc_o, 32'd0);
      check("mid_rst_valid",   32'(valid_o), 32'd0);
      check("mid_rst_pulse",   32'(pump_done_o), 32'd0);
      check("mid_rst_busy",    32'(busy_o), 32'd0);
      check("mid_rst_count",   32'(mac_count_o), 32'd0);
      check("mid_rst_ready",   32'(ready_o), 32'd1);
      @(negedge clk_i);
      rst_ni = 1'b1;
      ready_i = 1'b1;

      // Counter wrap: 17 completions on a 4-bit counter.
      for (int i = 0; i < 17; i++) begin
         logic [31:0] d;
         d = 32'(i);
         send(2'b00, d, 32'd3, 32'd1, 32'(3 * i + 1));
      end
      drain();
      check("count_wrap", 32'(mac_count_o), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
